// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (MIPS DIV semantics), one quotient bit per clock.
// Optional DIV_UNSIGNED_EN adds a div_unsigned input for DIVU; without it all divisions are signed.
//
// state | meaning
// IDLE  | waiting for div_control; latches operand magnitudes and signs
// CALC  | 32 restoring iterations, one quotient bit per edge
// FIX   | apply result signs, write lo_out/hi_out, raise div_end
// DONE  | completion cycle; also raises the divide-by-zero pulse one edge late
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        div_control,
`ifdef DIV_UNSIGNED_EN
    input  logic        div_unsigned,
`endif
    output logic [31:0] lo_out,
    output logic [31:0] hi_out,
    output logic        div_end,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [4:0]  cnt_q;
    logic        sa_q;
    logic        neg_q;
    logic        zero_q;
    logic        div_end_q;
    logic        div_zero_q;

    logic        signed_op;
    logic [31:0] a_mag_d;
    logic [31:0] b_mag_d;
    logic [32:0] shift_d;
    logic [32:0] trial_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~div_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Remainder stays below the divisor, so a 33-bit trial difference never
    // overflows and its MSB is the borrow in both signed and unsigned modes.
    always_comb begin
        a_mag_d = (signed_op && a[31]) ? (32'd0 - a) : a;
        b_mag_d = (signed_op && b[31]) ? (32'd0 - b) : b;
        shift_d = {rem_q, dvd_q[31]};
        trial_d = shift_d - {1'b0, dvs_q};
        rem_d   = trial_d[32] ? shift_d[31:0] : trial_d[31:0];
        quo_d   = {dvd_q[30:0], ~trial_d[32]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            sa_q       <= 1'b0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            div_end_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_end_q  <= 1'b0;
                    div_zero_q <= 1'b0;
                    if (div_control) begin
                        if (b == 32'd0) begin
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= a_mag_d;
                            dvs_q   <= b_mag_d;
                            sa_q    <= signed_op & a[31];
                            neg_q   <= signed_op & (a[31] ^ b[31]);
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            zero_q  <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q       <= neg_q ? (32'd0 - dvd_q) : dvd_q;
                    hi_q       <= sa_q ? (32'd0 - rem_q) : rem_q;
                    div_end_q  <= 1'b1;
                    div_zero_q <= 1'b0;
                    state_q    <= DONE;
                end
                DONE: begin
                    // A zero divisor reaches DONE straight from IDLE; its pulse is raised here.
                    div_end_q  <= zero_q;
                    div_zero_q <= zero_q;
                    zero_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign div_end  = div_end_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table of signed divisions plus hand-written
// sequences for abort-by-reset, ignored restart and back-to-back starts.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_control;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        div_end;
    logic        div_zero;
`ifdef DIV_UNSIGNED_EN
    logic        div_unsigned;
`endif

    always #5 clk = ~clk;

    div_seq dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .div_control (div_control),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned(div_unsigned),
`endif
        .lo_out      (lo_out),
        .hi_out      (hi_out),
        .div_end     (div_end),
        .div_zero    (div_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
    } vec_t;

    vec_t vecs [12];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Starts a division, scrambles the operands after the start edge, then
    // measures edges to div_end and checks results and the pulse width.
    task automatic run_div(input string nm, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] elo, input logic [31:0] ehi, input logic ezero);
        int lat;
        @(negedge clk);
        a = va;
        b = vb;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_end) break;
        end
        check32({nm, " latency"}, 32'(lat), ezero ? 32'd1 : 32'd33);
        check32({nm, " lo_out"}, lo_out, elo);
        check32({nm, " hi_out"}, hi_out, ehi);
        check32({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, ezero});
        @(posedge clk);
        #1;
        check32({nm, " div_end low"}, {31'd0, div_end}, 32'd0);
    endtask

    initial begin
        int lat;
        int first_lat;
        logic seen;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'd5,          32'd0,          32'd14,         32'd2,          1'b1};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[3]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[5]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7]  = '{32'd1,          32'h8000_0000,  32'd0,          32'd1,          1'b0};
        vecs[8]  = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'd0,          32'hC000_0000,  32'd0,          1'b1};
        vecs[10] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
        vecs[11] = '{32'd3,          32'd7,          32'd0,          32'd3,          1'b0};

        reset = 1'b0;
        div_control = 1'b0;
        a = '0;
        b = '0;
`ifdef DIV_UNSIGNED_EN
        div_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check32("reset lo_out", lo_out, 32'd0);
        check32("reset hi_out", hi_out, 32'd0);
        check32("reset div_end", {31'd0, div_end}, 32'd0);
        check32("reset div_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero);
        end

        // Abort: restart pulse at E5 must be ignored, reset at E10 kills the division.
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (div_end) seen = 1'b1;
            if (k == 4) div_control = 1'b1;
            if (k == 5) div_control = 1'b0;
            if (k == 9) reset = 1'b0;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        check32("abort lo_out", lo_out, 32'd0);
        check32("abort hi_out", hi_out, 32'd0);
        check32("abort div_zero", {31'd0, div_zero}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (div_end) seen = 1'b1;
        end
        check32("abort no div_end", {31'd0, seen}, 32'd0);
        run_div("after abort 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Held-high start: second division begins on the edge after DONE->IDLE.
        @(negedge clk);
        a = 32'd20;
        b = 32'd3;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd21;
        b = 32'd4;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_end) break;
        end
        first_lat = lat;
        check32("held first latency", 32'(first_lat), 32'd33);
        check32("held first lo_out", lo_out, 32'd6);
        check32("held first hi_out", hi_out, 32'd2);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_end) break;
        end
        div_control = 1'b0;
        check32("held second spacing", 32'(lat), 32'd35);
        check32("held second lo_out", lo_out, 32'd5);
        check32("held second hi_out", hi_out, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check32("held idle after", {31'd0, div_end}, 32'd0);

`ifdef DIV_UNSIGNED_EN
        div_unsigned = 1'b1;
        run_div("divu FFFFFFFE/2", 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd0, 1'b0);
        run_div("divu FFFFFFFF/10", 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 1'b0);
        div_unsigned = 1'b0;
        run_div("div FFFFFFFE/2", 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
